sd_frame_scheduler: RTL

SD_FRAME_SCHEDULER -- requirements
Module: sd_frame_scheduler

---
 rtl/sd_sched_pkg.sv | 19 +
 rtl/sd_sched_pipe.sv | 48 ++++
 rtl/sd_frame_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sd_sched_pkg.sv
// Shared definitions for the sigma-delta frame scheduler: FSM state
// encoding, flush length, pixel width and a saturating counter helper.
package sd_sched_pkg;

   typedef logic [1:0] sd_state_t;

   localparam sd_state_t ST_IDLE  = 2'd0;
   localparam sd_state_t ST_RUN   = 2'd1;
   localparam sd_state_t ST_FLUSH = 2'd2;

   localparam int FLUSH_CYCLES = 2;
   localparam int PIX_W        = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sd_sched_pipe.sv
// Two-stage delay line carrying the accepted pixel's valid bit, address
// and value from the memory read cycle to the datapath cycle (stage 1)
// and the write-back cycle (stage 2). i_clr drops everything in flight.
module sd_sched_pipe
   import sd_sched_pkg::*;
#(
   parameter int ADDR_W = 17
)(
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [PIX_W-1:0]  i_pix,
   output logic              o_s1_valid,
   output logic [PIX_W-1:0]  o_s1_pix,
   output logic              o_s2_valid,
   output logic [ADDR_W-1:0] o_s2_addr
);

   logic              r_s1_valid;
   logic [ADDR_W-1:0] r_s1_addr;
   logic [PIX_W-1:0]  r_s1_pix;
   logic              r_s2_valid;
   logic [ADDR_W-1:0] r_s2_addr;

   // Advance both stages every cycle; empty slots carry zeros.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_s1_valid <= 1'b0;
         r_s1_addr  <= {ADDR_W{1'b0}};
         r_s1_pix   <= {PIX_W{1'b0}};
         r_s2_valid <= 1'b0;
         r_s2_addr  <= {ADDR_W{1'b0}};
      end else begin
         r_s1_valid <= i_valid;
         r_s1_addr  <= i_valid ? i_addr : {ADDR_W{1'b0}};
         r_s1_pix   <= i_valid ? i_pix : {PIX_W{1'b0}};
         r_s2_valid <= r_s1_valid;
         r_s2_addr  <= r_s1_addr;
      end
   end

   assign o_s1_valid = r_s1_valid;
   assign o_s1_pix   = r_s1_pix;
   assign o_s2_valid = r_s2_valid;
   assign o_s2_addr  = r_s2_addr;

endmodule

// File: rtl/sd_frame_scheduler.sv
// Frame scheduler for a sigma-delta background subtractor: walks one frame
// of pixels, reads background/variance per pixel, feeds the datapath and
// writes its results back two cycles after acceptance.
// Optional build macro SD_SCHED_PERF_EN adds the stall_cnt output.
module sd_frame_scheduler
   import sd_sched_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              init_req,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [PIX_W-1:0]  pix_data,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PIX_W-1:0]  mem_rd_bg,
   input  logic [PIX_W-1:0]  mem_rd_var,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [PIX_W-1:0]  mem_wr_bg,
   output logic [PIX_W-1:0]  mem_wr_var,
   output logic              sd_enable,
   output logic              sd_wr_background,
   output logic [PIX_W-1:0]  sd_curr_pixel,
   output logic [PIX_W-1:0]  sd_background,
   output logic [PIX_W-1:0]  sd_variance,
   input  logic [PIX_W-1:0]  sd_background_next,
   input  logic [PIX_W-1:0]  sd_variance_next,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_cnt
`ifdef SD_SCHED_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(IMG_W*IMG_H-1);
   localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES-1);

   sd_state_t         r_state;
   logic [1:0]        r_flush_cnt;
   logic [ADDR_W-1:0] r_pix_idx;
   logic              r_init_pend;
   logic              r_init_frame;
   logic [15:0]       r_frame_cnt;

   logic              w_run;
   logic              w_accept;
   logic              w_start_ok;
   logic              w_s1_valid;
   logic [PIX_W-1:0]  w_s1_pix;
   logic              w_s2_valid;
   logic [ADDR_W-1:0] w_s2_addr;
   logic              w_s1_en;
   logic              w_s2_en;
   logic              w_done;

   // Strobes are held low while rst is asserted so nothing leaks out
   // in the cycle the reset is sampled.
   assign w_run      = (r_state == ST_RUN) && !rst;
   assign w_accept   = w_run && pix_valid;
   assign w_start_ok = (r_state == ST_IDLE) && start;
   assign w_s1_en    = w_s1_valid && !rst;
   assign w_s2_en    = w_s2_valid && !rst;
   assign w_done     = w_s2_en && (w_s2_addr == LAST_IDX);

   sd_sched_pipe #(
      .ADDR_W (ADDR_W)
   ) u_pipe (
      .i_clk      (clk),
      .i_clr      (rst),
      .i_valid    (w_accept),
      .i_addr     (r_pix_idx),
      .i_pix      (pix_data),
      .o_s1_valid (w_s1_valid),
      .o_s1_pix   (w_s1_pix),
      .o_s2_valid (w_s2_valid),
      .o_s2_addr  (w_s2_addr)
   );

   // Frame FSM: pixel index during RUN, fixed drain time in FLUSH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= 2'd0;
         r_pix_idx   <= {ADDR_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_RUN;
                  r_pix_idx <= {ADDR_W{1'b0}};
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  if (r_pix_idx == LAST_IDX) begin
                     r_state     <= ST_FLUSH;
                     r_flush_cnt <= 2'd0;
                     r_pix_idx   <= {ADDR_W{1'b0}};
                  end else begin
                     r_pix_idx <= r_pix_idx + ADDR_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (r_flush_cnt == FLUSH_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 2'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Pending init request, handed to the frame that starts next.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_init_pend  <= 1'b1;
         r_init_frame <= 1'b0;
      end else if (w_start_ok) begin
         r_init_frame <= r_init_pend | init_req;
         r_init_pend  <= 1'b0;
      end else begin
         if (init_req) begin
            r_init_pend <= 1'b1;
         end
         if (w_done) begin
            r_init_frame <= 1'b0;
         end
      end
   end

   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= 16'd0;
      end else if (w_done) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end

`ifdef SD_SCHED_PERF_EN
   logic [15:0] r_stall_cnt;

   // RUN cycles starved of input pixels, saturating, restarted per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (w_start_ok) begin
         r_stall_cnt <= 16'd0;
      end else if (w_run && !pix_valid) begin
         r_stall_cnt <= sat_inc16(r_stall_cnt);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign pix_ready        = w_run;
   assign busy             = (r_state != ST_IDLE);
   assign frame_done       = w_done;
   assign frame_cnt        = r_frame_cnt;

   assign mem_rd_en        = w_accept;
   assign mem_rd_addr      = w_accept ? r_pix_idx : {ADDR_W{1'b0}};

   assign sd_enable        = w_s1_en;
   assign sd_wr_background = w_s1_en && r_init_frame;
   assign sd_curr_pixel    = w_s1_en ? w_s1_pix : {PIX_W{1'b0}};
   assign sd_background    = w_s1_en ? mem_rd_bg : {PIX_W{1'b0}};
   assign sd_variance      = w_s1_en ? mem_rd_var : {PIX_W{1'b0}};

   assign mem_wr_en        = w_s2_en;
   assign mem_wr_addr      = w_s2_en ? w_s2_addr : {ADDR_W{1'b0}};
   assign mem_wr_bg        = w_s2_en ? sd_background_next : {PIX_W{1'b0}};
   assign mem_wr_var       = w_s2_en ? sd_variance_next : {PIX_W{1'b0}};

endmodule
